hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 7 +
 rtl/hazard_scoreboard_sb_entry.sv | 32 +++
 rtl/hazard_scoreboard.sv | 84 ++++++++
 tb/tb_hazard_scoreboard.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared forwarding encodings, FSM states and default latencies
package hazard_scoreboard_pkg;
  localparam int FWD_RF = 0;
  localparam int LAT_ALU = 1;
  localparam int LAT_LOAD = 2;
  typedef enum logic {RUN, FLUSH} state_t;
endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// sb_entry: one register's pending-latency and bypass-residency counters
module sb_entry
  import hazard_scoreboard_pkg::*;
#(
  parameter int LW = 3,
  parameter int BW = 2,
  parameter int NUM_BYP = 2
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          load,
  input  logic [LW-1:0] lat,
  output logic [LW-1:0] pend,
  output logic [BW-1:0] age
);
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      age <= '0;
    end else if (load) begin
      pend <= lat;
      age <= '0;
    end else if (!hold) begin
      if (pend > LW'(1)) pend <= pend - LW'(1);
      else if (pend == LW'(1)) begin
        pend <= '0;
        age <= BW'(NUM_BYP);
      end else if (age != '0) age <= age - BW'(1);
    end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: issue-stage RAW/WAW interlock, bypass select and redirect flush control
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MAX_LAT = 4,
  parameter int NUM_BYP = 2,
  parameter int FLUSH_CYCLES = 2,
  localparam int NREG = 2**REG_AW,
  localparam int LW = $clog2(MAX_LAT+1),
  localparam int BW = $clog2(NUM_BYP+1)
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              issue_we,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic [LW-1:0]     issue_lat,
  input  logic [REG_AW-1:0] issue_rs1,
  input  logic [REG_AW-1:0] issue_rs2,
  input  logic              use_rs1,
  input  logic              use_rs2,
  input  logic              ext_stall,
  input  logic              redirect,
  output logic              stall,
  output logic              flush,
  output logic [BW-1:0]     fwd_a,
  output logic [BW-1:0]     fwd_b,
  output logic [31:0]       stall_cnt
);
  localparam int FW = $clog2(FLUSH_CYCLES+1);
  logic [LW-1:0] pend [NREG];
  logic [BW-1:0] age [NREG];
  state_t state, state_n;
  logic [FW-1:0] fcnt, fcnt_n;
  logic raw, waw, fire;
  function automatic logic [BW-1:0] fwd_of(input logic [LW-1:0] p, input logic [BW-1:0] a);
    return (a != '0 && p == '0) ? BW'(NUM_BYP + 1) - a : BW'(FWD_RF);
  endfunction
  assign pend[0] = '0;
  assign age[0] = '0;
  for (genvar r = 1; r < NREG; r++) begin : g_e
    sb_entry #(.LW(LW), .BW(BW), .NUM_BYP(NUM_BYP)) u_e (
      .clk(clk),
      .rst(rst),
      .hold(ext_stall),
      .load(fire && issue_we && issue_rd == REG_AW'(r)),
      .lat(issue_lat),
      .pend(pend[r]),
      .age(age[r])
    );
  end
  assign raw = (use_rs1 && pend[issue_rs1] != '0) || (use_rs2 && pend[issue_rs2] != '0);
  assign waw = issue_we && issue_rd != '0 && pend[issue_rd] >= issue_lat;
  assign stall = ext_stall | raw | waw;
  assign flush = state == FLUSH;
  assign fire = issue_valid & ~stall & ~flush;
  assign fwd_a = fwd_of(pend[issue_rs1], age[issue_rs1]);
  assign fwd_b = fwd_of(pend[issue_rs2], age[issue_rs2]);
  always_comb begin
    state_n = state;
    fcnt_n = fcnt;
    if (redirect) begin
      state_n = FLUSH;
      fcnt_n = FW'(FLUSH_CYCLES);
    end else if (state == FLUSH && !ext_stall) begin
      fcnt_n = fcnt - FW'(1);
      state_n = fcnt == FW'(1) ? RUN : FLUSH;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      fcnt <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_n;
      fcnt <= fcnt_n;
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
  end
  a_lat_legal: assert property (@(posedge clk) disable iff (rst)
    (issue_valid && issue_we) |-> (issue_lat >= LW'(1) && int'(issue_lat) <= MAX_LAT));
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vectors checked against a countdown model of the scoreboard
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;
  localparam int REG_AW = 5, MAX_LAT = 4, NUM_BYP = 2, FLUSH_CYCLES = 2;
  localparam int NREG = 32, LW = 3, BW = 2;
  logic clk, rst, issue_valid, issue_we, use_rs1, use_rs2, ext_stall, redirect;
  logic [REG_AW-1:0] issue_rd, issue_rs1, issue_rs2;
  logic [LW-1:0] issue_lat;
  logic stall, flush;
  logic [BW-1:0] fwd_a, fwd_b;
  logic [31:0] stall_cnt;
  int tests = 0, fails = 0;
  bit chk = 0;
  int cnt [NREG];
  int fl = 0;
  longint sc = 0;
  hazard_scoreboard #(.REG_AW(REG_AW), .MAX_LAT(MAX_LAT), .NUM_BYP(NUM_BYP), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
    .issue_lat(issue_lat), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .use_rs1(use_rs1),
    .use_rs2(use_rs2), .ext_stall(ext_stall), .redirect(redirect), .stall(stall), .flush(flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  // cnt[r]: cycles left until r leaves the bypass network; > NUM_BYP means result not yet produced
  function automatic int mfwd(input int s);
    return (s != 0 && cnt[s] > 0 && cnt[s] <= NUM_BYP) ? NUM_BYP + 1 - cnt[s] : 0;
  endfunction
  function automatic bit mstall();
    return ext_stall || (use_rs1 && cnt[int'(issue_rs1)] > NUM_BYP) || (use_rs2 && cnt[int'(issue_rs2)] > NUM_BYP)
      || (issue_we && issue_rd != 0 && cnt[int'(issue_rd)] - NUM_BYP >= int'(issue_lat));
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= 0;
      fl <= 0;
      sc <= 0;
    end else begin
      for (int r = 1; r < NREG; r++)
        if (issue_valid && !mstall() && fl == 0 && issue_we && int'(issue_rd) == r) cnt[r] <= int'(issue_lat) + NUM_BYP;
        else if (!ext_stall && cnt[r] > 0) cnt[r] <= cnt[r] - 1;
      fl <= redirect ? FLUSH_CYCLES : (fl > 0 && !ext_stall) ? fl - 1 : fl;
      if (mstall()) sc <= sc + 1;
    end
  end
  task automatic check(input string n, input longint a, input longint e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (chk) begin
      check("m_stall", longint'(stall), longint'(mstall()));
      check("m_flush", longint'(flush), longint'(fl > 0));
      check("m_fwd_a", longint'(fwd_a), longint'(mfwd(int'(issue_rs1))));
      check("m_fwd_b", longint'(fwd_b), longint'(mfwd(int'(issue_rs2))));
      check("m_stall_cnt", longint'(stall_cnt), sc);
    end
  end
  task automatic idle();
    issue_valid = 0; issue_we = 0; issue_rd = 0; issue_lat = LW'(LAT_ALU);
    issue_rs1 = 0; issue_rs2 = 0; use_rs1 = 0; use_rs2 = 0; ext_stall = 0; redirect = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask
  task automatic issue(input int rd, input int lat);
    idle();
    issue_valid = 1; issue_we = 1; issue_rd = REG_AW'(rd); issue_lat = LW'(lat);
  endtask
  initial begin
    idle();
    rst = 1;
    tick();
    chk = 1;
    tick();
    rst = 0;
    #1 check("rst_flush", flush, 0); check("rst_stall", stall, 0);
    check("rst_fwd_a", fwd_a, 0); check("rst_stall_cnt", stall_cnt, 0);
    ext_stall = 1;
    #1 check("rst_stall_ext", stall, 1);
    ext_stall = 0;
    tick();
    issue(5, LAT_ALU);
    #1 check("a_issue_stall", stall, 0);
    tick();
    idle(); issue_valid = 1; use_rs1 = 1; issue_rs1 = 5;
    #1 check("a_dep_stall", stall, 1); check("a_dep_fwd", fwd_a, 0);
    tick();
    #1 check("a_fwd1", fwd_a, 1); check("a_go", stall, 0); check("a_stall_cnt", stall_cnt, 1);
    tick();
    issue_valid = 0;
    #1 check("a_fwd2", fwd_a, 2);
    tick();
    #1 check("a_fwd_rf", fwd_a, 0);
    do_reset();
    issue(7, LAT_LOAD);
    tick();
    idle(); issue_valid = 1; use_rs2 = 1; issue_rs2 = 7;
    #1 check("b_stall1", stall, 1);
    tick();
    #1 check("b_stall2", stall, 1);
    tick();
    #1 check("b_fwd_b", fwd_b, 1); check("b_go", stall, 0); check("b_stall_cnt", stall_cnt, 2);
    tick();
    do_reset();
    issue(7, LAT_LOAD);
    tick();
    issue(7, LAT_ALU);
    #1 check("c_waw1", stall, 1);
    tick();
    #1 check("c_waw2", stall, 1);
    tick();
    #1 check("c_waw_go", stall, 0);
    tick();
    idle(); use_rs1 = 1; issue_rs1 = 7;
    #1 check("c_alu_pend", stall, 1);
    tick();
    issue(8, LAT_LOAD); issue_rs1 = 7;
    #1 check("c_fwd_a", fwd_a, 1); check("c_x8_go", stall, 0);
    tick();
    issue(8, 2);
    #1 check("c_waw_eq", stall, 1);
    issue_lat = LW'(3);
    #1 check("c_waw_gt", stall, 0);
    tick();
    idle(); use_rs1 = 1; issue_rs1 = 8;
    #1 check("c_x8_lat3", stall, 1);
    do_reset();
    redirect = 1;
    tick();
    issue(3, LAT_ALU);
    #1 check("d_flush1", flush, 1);
    tick();
    #1 check("d_flush2", flush, 1);
    tick();
    idle(); use_rs1 = 1; issue_rs1 = 3;
    #1 check("d_flush_end", flush, 0); check("d_x3_untracked", stall, 0);
    tick();
    idle(); redirect = 1;
    tick();
    #1 check("d_flush_a", flush, 1);
    tick();
    redirect = 0;
    begin
      int n = 1;
      for (int k = 0; k < 8; k++) begin
        #1;
        if (!flush) break;
        n++;
        tick();
      end
      check("d_flush_len", n, 3);
    end
    do_reset();
    issue(9, LAT_LOAD);
    tick();
    for (int k = 0; k < 3; k++) begin
      idle(); ext_stall = 1; use_rs1 = 1; issue_rs1 = 9;
      #1 check("e_ext_stall", stall, 1);
      tick();
    end
    idle(); use_rs1 = 1; issue_rs1 = 9;
    #1 check("e_frozen1", stall, 1);
    tick();
    #1 check("e_frozen2", stall, 1);
    tick();
    #1 check("e_fwd", fwd_a, 1); check("e_go", stall, 0); check("e_stall_cnt", stall_cnt, 5);
    tick();
    issue(11, 4);
    tick();
    idle(); redirect = 1; use_rs1 = 1; issue_rs1 = 11;
    tick();
    redirect = 0; rst = 1;
    #1 check("f_pre_rst_flush", flush, 1);
    tick();
    rst = 0;
    #1 check("f_stall", stall, 0); check("f_fwd_a", fwd_a, 0);
    check("f_flush", flush, 0); check("f_stall_cnt", stall_cnt, 0);
    tick();
    issue(0, LAT_LOAD);
    tick();
    idle(); issue_valid = 1; issue_we = 1; issue_rd = 0; use_rs1 = 1; use_rs2 = 1;
    #1 check("g_x0_stall", stall, 0); check("g_x0_fwd", fwd_a, 0);
    tick();
    idle();
    tick();
    tick();
    chk = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
